platform_scheduler: RTL
=======================

Name: platform_scheduler

Overview:
Game-level controller that owns the 8-entry platform table consumed by `doodle` and the renderer. It sequences the run-time game FSM (menu, init, play, game over). On each frame it scrolls the world when the doodle climbs above a threshold, recycles platforms that leave the bottom of the screen back to the top with a pseudo-random X position, and counts score. Platform entries are updated serially, one per clock, after each frame edge.

Parameters:
H, 480, screen height in pixels
X_min, 140, leftmost playfield X
X_max, 499, rightmost playfield X
PLAT_SIZE, 60, platform width in pixels; driven on platform_size
PLAT_GAP, 60, vertical spacing between platforms; 8*PLAT_GAP must equal H
SCROLL_Y, 160, doodle Y above which the world scrolls
MAX_SCROLL, 16, per-frame scroll clamp
OVER_Y, 446, doodle Y at or beyond which the game is over
KEY_START, 8'h28, keycode (Enter) that starts or restarts the game

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  asynchronous, active-high reset
frame_clk_edge  in  2  frame edge detector; 2'b01 marks the frame rising edge
keycode  in  8  current USB keycode
Doodle_Y  in  10  doodle top-left Y from `doodle`
Platform_X  out  10 x [0:7]  platform left X
Platform_Y  out  10 x [0:7]  platform top Y
platform_size  out  8  constant PLAT_SIZE
state  out  8  0 = menu, 1 = play (includes INIT and SCROLL), 2 = game over
score  out  16  recycled-platform count, saturating at 16'hFFFF
scroll_dy  out  10  scroll applied in the current frame
busy  out  1  high while the table is being rewritten

Behaviour:
- Reset (async, active-high) values:
  - FSM = IDLE; all Platform_X/Y = 0; score = 0; scroll_dy = 0; busy = 0; idx = 0; LFSR = 16'hACE1.
  - Reset asserted mid-INIT or mid-SCROLL aborts the sweep immediately; partially updated entries are discarded to reset values.
- FSM states: IDLE, INIT, PLAY, SCROLL, OVER.
  - IDLE: state = 0. keycode == KEY_START on any clock -> INIT, with idx = 0, score = 0, busy = 1.
  - INIT: 8 clocks, one entry per clock (idx 0..7).
    - Platform_Y[idx] = H-40-idx*PLAT_GAP, giving 440, 380, ..., 20.
    - Platform_X[idx] = rand_x; LFSR advances once.
    - After idx = 7 -> PLAY, busy = 0.
  - PLAY: state = 1. Actions taken only when frame_clk_edge == 2'b01, in this priority order:
    1. Doodle_Y >= OVER_Y -> OVER; table frozen; scroll_dy = 0.
    2. Doodle_Y < SCROLL_Y -> latch scroll_dy = min(SCROLL_Y-Doodle_Y, MAX_SCROLL); go to SCROLL with idx = 0, busy = 1.
    3. Otherwise latch scroll_dy = 0 and stay in PLAY.
  - SCROLL: 8 clocks, idx 0..7.
    - ny = Platform_Y[idx] + scroll_dy, computed 11 bits wide.
    - If ny >= H: Platform_Y[idx] = ny - H; Platform_X[idx] = rand_x; LFSR advances; score += 1 (saturating).
    - Else: Platform_Y[idx] = ny; X unchanged.
    - After idx = 7 -> PLAY, busy = 0.
  - OVER: state = 2. keycode == KEY_START -> INIT. A restart clears score.
- Timing: frame edge sampled at cycle t. scroll_dy is valid from t+1. Entry k is updated at the edge ending cycle t+1+k. busy falls at t+9. scroll_dy holds until the next frame edge.
- A frame edge arriving while busy is ignored (no queuing). KEY_START in PLAY or SCROLL is ignored.
- rand_x: with r = LFSR[8:0] and RANGE = X_max-X_min+1-PLAT_SIZE (300):
  - rand_x = X_min + (r >= RANGE ? r-256 : r).
  - Requires 256 < RANGE <= 512; this is checked by an elaboration assertion.
- LFSR: 16-bit Galois, right shift, taps 16'hB400. It advances only when an X value is generated, so the sequence is deterministic for the bench.
- With SCROLL_Y = 160 and MAX_SCROLL = 16, scroll_dy is at most 16 and never negative.

Decomposition:
- Package platform_pkg holds:
  - enum game_state_e {IDLE, INIT, PLAY, SCROLL, OVER};
  - NUM_PLATFORMS = 8;
  - state output encodings STATE_MENU = 0, STATE_PLAY = 1, STATE_OVER = 2;
  - KEY_START;
  - LFSR_SEED, LFSR_TAPS.
- One sub-module, platform_lfsr: 16-bit Galois LFSR with ports Clk, Reset, advance, value.

Test Plan:
1. Reset, then hold 20 clocks with keycode = 0 -> state = 0, all Platform_X/Y = 0, score = 0, busy = 0.
2. keycode = 8'h28 for 1 clock -> busy high for 8 clocks; Platform_Y = 440, 380, ..., 20; Platform_X matches the LFSR model, with X[0] computed from seed 16'hACE1 and every X in 140..439; state = 1.
3. In PLAY, Doodle_Y = 100 with a frame edge -> scroll_dy = 16; Platform_Y[1] goes 380 -> 396 after 9 clocks. Doodle_Y = 150 -> scroll_dy = 10. Doodle_Y = 200 -> scroll_dy = 0 and no SCROLL.
4. Force Platform_Y[0] to 470 via prior scrolls, then scroll_dy = 16 -> Y[0] = 6, X[0] takes a new LFSR value, score increments by exactly 1; entries not crossing H keep their X.
5. Doodle_Y = 446 together with a frame edge, with Doodle_Y also < SCROLL_Y impossible, so only the over path applies -> state = 2, table frozen across 3 further frame edges. keycode = 8'h28 -> INIT, score = 0.
6. Assert Reset at cycle t+4 of a SCROLL sweep -> all outputs return to reset values asynchronously and state = 0; a second frame edge while busy produces no extra sweep.

Source files
------------

// File: rtl/platform_pkg.sv
`default_nettype none
// ============================================================================
// Module      : platform_pkg
// Description : Shared types and constants for the platform scheduler:
//               game FSM states, table size, external state encodings,
//               start keycode and LFSR seed/taps.
// Revision    : 1.0 - initial release
// ============================================================================
package platform_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    PLAY   = 3'd2,
    SCROLL = 3'd3,
    OVER   = 3'd4
  } game_state_e;

  localparam int          NUM_PLATFORMS = 8;

  localparam logic [7:0]  STATE_MENU = 8'd0;
  localparam logic [7:0]  STATE_PLAY = 8'd1;
  localparam logic [7:0]  STATE_OVER = 8'd2;

  localparam logic [7:0]  KEY_START  = 8'h28;

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

endpackage
`default_nettype wire

// File: rtl/platform_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : platform_lfsr
// Description : 16-bit right-shifting Galois LFSR. Steps only when
//               'advance' is high so consumers control the sequence.
// Ports       : Clk     - clock
//               Reset   - asynchronous active-high reset (loads SEED)
//               advance - step the register this clock
//               value   - current register contents
// Revision    : 1.0 - initial release
// ============================================================================
module platform_lfsr
  import platform_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED,
  parameter logic [15:0] TAPS = LFSR_TAPS
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] r_value;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_value <= SEED;
    end else if (advance) begin
      r_value <= {1'b0, r_value[15:1]} ^ (r_value[0] ? TAPS : 16'h0000);
    end
  end

  assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/platform_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : platform_scheduler
// Description : Game-level controller owning the 8-entry platform table.
//               Runs the menu/init/play/scroll/over FSM, scrolls the world
//               when the doodle climbs above SCROLL_Y, recycles platforms
//               that fall off the bottom to the top with a pseudo-random X,
//               and counts recycled platforms as score. Table entries are
//               rewritten one per clock after the triggering event.
// Ports       : Clk, Reset        - clock, async active-high reset
//               frame_clk_edge    - 2'b01 marks a frame rising edge
//               keycode           - current USB keycode
//               Doodle_Y          - doodle top-left Y
//               Platform_X/Y[0:7] - platform table
//               platform_size     - constant platform width
//               state             - 0 menu, 1 play, 2 game over
//               score             - saturating recycled-platform count
//               scroll_dy         - scroll applied in the current frame
//               busy              - table rewrite in progress
// Revision    : 1.0 - initial release
// ============================================================================
module platform_scheduler
  import platform_pkg::*;
#(
  parameter int H          = 480,
  parameter int X_MIN      = 140,
  parameter int X_MAX      = 499,
  parameter int PLAT_SIZE  = 60,
  parameter int PLAT_GAP   = 60,
  parameter int SCROLL_Y   = 160,
  parameter int MAX_SCROLL = 16,
  parameter int OVER_Y     = 446
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  frame_clk_edge,
  input  logic [7:0]  keycode,
  input  logic [9:0]  Doodle_Y,
  output logic [9:0]  Platform_X [0:NUM_PLATFORMS-1],
  output logic [9:0]  Platform_Y [0:NUM_PLATFORMS-1],
  output logic [7:0]  platform_size,
  output logic [7:0]  state,
  output logic [15:0] score,
  output logic [9:0]  scroll_dy,
  output logic        busy
);

  localparam int RANGE = X_MAX - X_MIN + 1 - PLAT_SIZE;

  // The fold-back in rand_x only covers one wrap of 256, so the range must
  // lie in (256, 512]; the table also has to tile the screen exactly.
  generate
    if (!(RANGE > 256 && RANGE <= 512) || (NUM_PLATFORMS * PLAT_GAP != H)) begin : g_bad_params
      $fatal(1, "platform_scheduler: invalid X range or platform gap");
    end
  endgenerate

  game_state_e r_state;
  logic [2:0]  r_idx;
  logic [9:0]  r_plat_x [0:NUM_PLATFORMS-1];
  logic [9:0]  r_plat_y [0:NUM_PLATFORMS-1];
  logic [15:0] r_score;
  logic [9:0]  r_scroll_dy;
  logic        r_busy;

  logic [15:0] w_lfsr;
  logic [8:0]  w_r;
  logic [8:0]  w_off;
  logic [9:0]  w_rand_x;
  logic [10:0] w_ny;
  logic        w_wrap;
  logic        w_advance;
  logic        w_frame;
  logic        w_start;
  logic [9:0]  w_climb;
  logic [9:0]  w_dy;
  logic [9:0]  w_init_y;
  logic        w_unused_lfsr;

  assign w_frame = (frame_clk_edge == 2'b01);
  assign w_start = (keycode == KEY_START);

  // Values of r at or past RANGE are folded back by 256 so every X lands
  // inside the playfield while keeping the draw cheap.
  assign w_r      = w_lfsr[8:0];
  assign w_off    = ({1'b0, w_r} >= 10'(RANGE)) ? (w_r - 9'd256) : w_r;
  assign w_rand_x = 10'(X_MIN) + {1'b0, w_off};
  assign w_unused_lfsr = ^w_lfsr[15:9];

  assign w_ny   = {1'b0, r_plat_y[r_idx]} + {1'b0, r_scroll_dy};
  assign w_wrap = (w_ny >= 11'(H));

  assign w_init_y = 10'(H - 40 - int'(r_idx) * PLAT_GAP);

  assign w_climb = 10'(SCROLL_Y) - Doodle_Y;
  assign w_dy    = (w_climb > 10'(MAX_SCROLL)) ? 10'(MAX_SCROLL) : w_climb;

  // LFSR steps exactly once for every X value consumed.
  assign w_advance = (r_state == INIT) || ((r_state == SCROLL) && w_wrap);

  platform_lfsr #(
    .SEED (LFSR_SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .Clk     (Clk),
    .Reset   (Reset),
    .advance (w_advance),
    .value   (w_lfsr)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_idx       <= 3'd0;
      r_score     <= 16'd0;
      r_scroll_dy <= 10'd0;
      r_busy      <= 1'b0;
      for (int i = 0; i < NUM_PLATFORMS; i++) begin
        r_plat_x[i] <= 10'd0;
        r_plat_y[i] <= 10'd0;
      end
    end else begin
      case (r_state)
        IDLE, OVER: begin
          if (w_start) begin
            r_state <= INIT;
            r_idx   <= 3'd0;
            r_score <= 16'd0;
            r_busy  <= 1'b1;
          end
        end

        INIT: begin
          r_plat_y[r_idx] <= w_init_y;
          r_plat_x[r_idx] <= w_rand_x;
          r_idx           <= r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            r_state <= PLAY;
            r_busy  <= 1'b0;
          end
        end

        PLAY: begin
          if (w_frame) begin
            if (Doodle_Y >= 10'(OVER_Y)) begin
              r_state     <= OVER;
              r_scroll_dy <= 10'd0;
            end else if (Doodle_Y < 10'(SCROLL_Y)) begin
              r_state     <= SCROLL;
              r_scroll_dy <= w_dy;
              r_idx       <= 3'd0;
              r_busy      <= 1'b1;
            end else begin
              r_scroll_dy <= 10'd0;
            end
          end
        end

        SCROLL: begin
          if (w_wrap) begin
            r_plat_y[r_idx] <= 10'(w_ny - 11'(H));
            r_plat_x[r_idx] <= w_rand_x;
            if (r_score != 16'hFFFF) begin
              r_score <= r_score + 16'd1;
            end
          end else begin
            r_plat_y[r_idx] <= w_ny[9:0];
          end
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            r_state <= PLAY;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    state = STATE_PLAY;
    case (r_state)
      IDLE:    state = STATE_MENU;
      OVER:    state = STATE_OVER;
      default: state = STATE_PLAY;
    endcase
  end

  assign Platform_X    = r_plat_x;
  assign Platform_Y    = r_plat_y;
  assign platform_size = 8'(PLAT_SIZE);
  assign score         = r_score;
  assign scroll_dy     = r_scroll_dy;
  assign busy          = r_busy;

endmodule
`default_nettype wire
